readdata_queue: RTL and testbench
=================================

# readdata_queue

Load-return path of the memory stage, opposite the store byte-lane/enable generator. For each issued load it queues the op, byte offset and destination register. When in-order memory read data returns, it selects and extends the addressed byte, halfword or word and delivers a registered writeback result. Sits between the data-memory response port and the writeback stage.

## Interface
- DEPTH, 4: number of outstanding load entries; power of two, at least 2.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  load issued this cycle.
- req_ready  out  1  entry available; equals !full && !flush.
- req_op  in  decoded_op_t  LB, LBU, LH, LHU or LW (plus LWL and LWR when configured).
- req_addr  in  2  byte offset, addr[1:0].
- req_rt  in  word_t  current rt value; used only by LWL and LWR.
- req_dst  in  5  writeback register number.
- resp_valid  in  1  memory read word valid.
- resp_ready  out  1  response consumed this cycle.
- resp_data  in  word_t  aligned 32-bit word from memory.
- flush  in  1  discard all outstanding loads.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_data  out  word_t  extracted, extended result.
- out_dst  out  5  destination register of the result.

## Operation
- Metadata FIFO of DEPTH entries. Each entry holds {op, addr, rt, dst, drop}.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The count is log2(DEPTH)+1 bits.
- Push when req_valid && req_ready.
  - On push, drop is set to 0.
- resp_ready = !empty && (head.drop || !out_valid || out_ready).
  - The pop happens when resp_valid && resp_ready.
  - resp_valid while empty is a protocol violation. The response is ignored and no state changes.
- Responses match entries strictly in order. A response never matches an entry pushed in the same cycle.
- Extraction on pop (lane = addr):
  - LW: resp_data.
  - LH / LHU: addr[1]=0 selects [15:0]; addr[1]=1 selects [31:16]. LH sign-extends; LHU zero-extends.
  - LB / LBU: lane 0..3 selects [7:0], [15:8], [23:16], [31:24]. LB sign-extends; LBU zero-extends.
  - Any other op yields 0; out_dst is still delivered.
- Output register: on a pop with drop=0, load out_data and out_dst, and set out_valid=1.
- out_valid clears when out_ready is high and no new pop occurs in that cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - With a full FIFO, no push occurs because req_ready is low. There is no pass-through.
- Flush:
  - In the flush cycle, every entry present has drop set to 1, and out_valid clears on the next edge.
  - A pop in the flush cycle produces no output.
  - Dropped entries still consume their memory responses later, with no output.
  - Requests are refused during the flush cycle.
  - Count is unaffected by flush; it drains only through responses.

## Timing
- Reset values: req_ready=1, resp_ready=0, out_valid=0, out_data=0, out_dst=0. Pointers, count and all drop bits are 0.
- Latency: a response accepted on edge N gives out_valid=1 with data after edge N, i.e. 1 cycle.
- Throughput: one result per cycle while out_ready stays high.
- Back-to-back pops with out_ready held low: after the first pop, resp_ready is 0 until the output drains.
- Reset asserted mid-operation clears all queued entries immediately. Responses still in flight at memory must be discarded by memory reset.
- req_ready and resp_ready are combinational from registered state plus out_ready and flush. There is no path from resp_valid.

## Configuration
- LOAD_UNALIGNED_EN defined: LWL and LWR are supported and merge resp_data with the stored rt (little-endian):
  - LWL, addr 0..3: {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
  - LWR, addr 0..3: d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
- Not defined: the rt field is not stored, and LWL and LWR fall into the "other op" case with out_data=0.

## Test plan
- Sign and zero extension: resp_data=32'h8081_F2F3.
  - LB addr 3 → FFFF_FF80.
  - LBU addr 0 → 0000_00F3.
  - LH addr 2 → FFFF_8081.
  - LHU addr 0 → 0000_F2F3.
  - LW → 8081_F2F3.
  - out_dst matches each request.
- Fill and wrap:
  - Push 4 loads with no responses → req_ready=0 on the fifth cycle.
  - Return 4 responses back-to-back with out_ready=1 → 4 results in order, each 1 cycle after its response.
  - Repeat 3 times to wrap the pointers.
- Backpressure: with out_ready=0, 2 queued loads and resp_valid held high:
  - The first pop is accepted, then resp_ready=0.
  - Raising out_ready accepts the second one cycle later, and no result is lost.
- Flush with 3 outstanding loads, then one new LW (dst 7):
  - The next 3 responses produce no out_valid.
  - The fourth response produces out_valid with dst 7.
- Reset mid-stream: deassert resetn while 2 loads are queued and out_valid=1 → all outputs return to their reset values asynchronously.
- With LOAD_UNALIGNED_EN: LWL addr 1, rt=1122_3344, d=AABB_CCDD → CCDD_3344. LWR addr 2, same values → 1122_AABB.

Source files
------------

// File: rtl/readdata_queue_if.sv
// Shared types and the load-return bus for readdata_queue.
// The package holds the data word and decoded load-op types. The interface
// groups the request, memory-response, flush and writeback handshakes.
// The slave modport is the queue's own view of the bus.

package readdata_queue_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    OP_LB   = 3'd0,
    OP_LBU  = 3'd1,
    OP_LH   = 3'd2,
    OP_LHU  = 3'd3,
    OP_LW   = 3'd4,
    OP_LWL  = 3'd5,
    OP_LWR  = 3'd6,
    OP_NONE = 3'd7
  } decoded_op_t;

endpackage

interface readdata_queue_if;
  import readdata_queue_pkg::*;

  // load issue
  logic        req_valid;
  logic        req_ready;
  decoded_op_t req_op;
  logic [1:0]  req_addr;
  word_t       req_rt;
  logic [4:0]  req_dst;

  // memory read response
  logic        resp_valid;
  logic        resp_ready;
  word_t       resp_data;

  // pipeline flush
  logic        flush;

  // writeback result
  logic        out_valid;
  logic        out_ready;
  word_t       out_data;
  logic [4:0]  out_dst;

  modport slave (
    input  req_valid, req_op, req_addr, req_rt, req_dst,
    output req_ready,
    input  resp_valid, resp_data,
    output resp_ready,
    input  flush,
    output out_valid, out_data, out_dst,
    input  out_ready
  );

  modport master (
    output req_valid, req_op, req_addr, req_rt, req_dst,
    input  req_ready,
    output resp_valid, resp_data,
    input  resp_ready,
    output flush,
    input  out_valid, out_data, out_dst,
    output out_ready
  );

endinterface

// File: rtl/readdata_queue.sv
// readdata_queue: load-return path of the memory stage.
// Each issued load is queued with its op, byte offset, destination register
// and a drop flag. In-order memory responses pop the head entry. The addressed
// byte, halfword or word is extracted, extended and registered for writeback.
// A flush marks every queued entry as dropped. Dropped entries still consume
// their responses but produce no result.
// Optional feature: define LOAD_UNALIGNED_EN to support LWL/LWR. These merge
// the response with the stored rt value. When the macro is undefined, rt is
// not stored and both ops produce 0.

module readdata_queue
  import readdata_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              resetn,
  readdata_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    decoded_op_t op;
    logic [1:0]  addr;
    logic [4:0]  dst;
  } meta_t;

  meta_t            meta_mem [DEPTH];
`ifdef LOAD_UNALIGNED_EN
  word_t            rt_mem   [DEPTH];
  word_t            head_rt;
`else
  logic             unused_rt;
`endif
  logic [DEPTH-1:0] drop_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             out_valid_q;
  word_t            out_data_q;
  logic [4:0]       out_dst_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  meta_t            head;
  logic             head_drop;
  word_t            extracted;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign head      = meta_mem[rd_ptr];
  assign head_drop = drop_q[rd_ptr];

  // Both readies depend only on registered state, out_ready and flush.
  // They do not depend on resp_valid.
  assign bus.req_ready  = !full && !bus.flush;
  assign bus.resp_ready = !empty && (head_drop || !out_valid_q || bus.out_ready);

  assign push = bus.req_valid  && bus.req_ready;
  assign pop  = bus.resp_valid && bus.resp_ready;

`ifdef LOAD_UNALIGNED_EN
  assign head_rt = rt_mem[rd_ptr];
`else
  assign unused_rt = ^bus.req_rt;
`endif

  // Entry payload storage, written on push.
  // NOTE: payload arrays have no reset; an entry is only read after a push has
  // written it, and the drop bits, pointers and count carry all reset state.
  always_ff @(posedge clk) begin
    if (push) begin
      meta_mem[wr_ptr] <= '{op: bus.req_op, addr: bus.req_addr, dst: bus.req_dst};
`ifdef LOAD_UNALIGNED_EN
      rt_mem[wr_ptr]   <= bus.req_rt;
`endif
    end
  end

  // FIFO pointers, occupancy and per-entry drop flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff block sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      // Flush and push are exclusive because req_ready is low during flush.
      if (bus.flush)  drop_q <= '1;
      else if (push)  drop_q[wr_ptr] <= 1'b0;
    end
  end

  // Select the addressed lane from the response word and extend it.
  always_comb begin
    // NOTE: default assignments first so no path leaves a variable unassigned
    // and no latch is inferred.
    extracted = '0;
    byte_sel  = bus.resp_data[{head.addr, 3'b000} +: 8];
    half_sel  = head.addr[1] ? bus.resp_data[31:16] : bus.resp_data[15:0];
    case (head.op)
      OP_LB:  extracted = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: extracted = {24'h0, byte_sel};
      OP_LH:  extracted = {{16{half_sel[15]}}, half_sel};
      OP_LHU: extracted = {16'h0, half_sel};
      OP_LW:  extracted = bus.resp_data;
`ifdef LOAD_UNALIGNED_EN
      OP_LWL: begin
        case (head.addr)
          2'd0:    extracted = {bus.resp_data[7:0],  head_rt[23:0]};
          2'd1:    extracted = {bus.resp_data[15:0], head_rt[15:0]};
          2'd2:    extracted = {bus.resp_data[23:0], head_rt[7:0]};
          default: extracted = bus.resp_data;
        endcase
      end
      OP_LWR: begin
        case (head.addr)
          2'd0:    extracted = bus.resp_data;
          2'd1:    extracted = {head_rt[31:24], bus.resp_data[31:8]};
          2'd2:    extracted = {head_rt[31:16], bus.resp_data[31:16]};
          default: extracted = {head_rt[31:8],  bus.resp_data[31:24]};
        endcase
      end
`endif
      default: extracted = '0;
    endcase
  end

  // Writeback output register: load on a live pop; clear on flush or drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (pop && !head_drop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= extracted;
      out_dst_q   <= head.dst;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_dst   = out_dst_q;

endmodule

// File: tb/tb_readdata_queue.sv
// Self-checking bench for readdata_queue.
// A reference model tracks queued loads, and a scoreboard holds expected
// writeback results. Results are pushed when a response is accepted and
// popped when writeback takes them.

module tb_readdata_queue;
  import readdata_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    decoded_op_t op;
    logic [1:0]  addr;
    word_t       rt;
    logic [4:0]  dst;
    logic        drop;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;

  readdata_queue_if bus ();

  readdata_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  ent_t        m_q[$];
  logic [36:0] sb[$];
  logic        m_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Byte-lane model: works on byte positions rather than on fixed slices.
  function automatic word_t model_extract(decoded_op_t op, logic [1:0] a, word_t rt, word_t d);
    word_t r;
    int    ia;
    ia = int'(a);
    r  = '0;
    case (op)
      OP_LB:  begin r = d >> (8 * ia);       r = {{24{r[7]}}, r[7:0]};   end
      OP_LBU: begin r = d >> (8 * ia);       r = {24'h0, r[7:0]};        end
      OP_LH:  begin r = d >> (16 * (ia / 2)); r = {{16{r[15]}}, r[15:0]}; end
      OP_LHU: begin r = d >> (16 * (ia / 2)); r = {16'h0, r[15:0]};      end
      OP_LW:  r = d;
`ifdef LOAD_UNALIGNED_EN
      OP_LWL: begin
        r = rt;
        for (int i = 0; i <= ia; i++) r[8 * (3 - ia + i) +: 8] = d[8 * i +: 8];
      end
      OP_LWR: begin
        r = rt;
        for (int i = ia; i <= 3; i++) r[8 * (i - ia) +: 8] = d[8 * i +: 8];
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic clear_inputs();
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_LW;
    bus.req_addr   = 2'd0;
    bus.req_rt     = '0;
    bus.req_dst    = 5'd0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive_req(input decoded_op_t op, input logic [1:0] a, input word_t rt, input logic [4:0] dst);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_rt    = rt;
    bus.req_dst   = dst;
  endtask

  task automatic drive_resp(input word_t d);
    bus.resp_valid = 1'b1;
    bus.resp_data  = d;
  endtask

  // One clock cycle. It is called at a negedge with inputs already driven.
  // It checks the handshakes and output, advances the model, and returns at
  // the next negedge with the pulsed inputs cleared.
  task automatic tick();
    logic exp_req_rdy, exp_resp_rdy, push, pop, nov;
    ent_t e;
    logic [36:0] r;
    #1;
    exp_req_rdy  = (m_q.size() < DEPTH) && !bus.flush;
    exp_resp_rdy = (m_q.size() != 0) && (m_q[0].drop || !m_ov || bus.out_ready);
    check("req_ready",  32'(bus.req_ready),  32'(exp_req_rdy));
    check("resp_ready", 32'(bus.resp_ready), 32'(exp_resp_rdy));
    check("out_valid",  32'(bus.out_valid),  32'(m_ov));
    if (m_ov && bus.out_ready && sb.size() != 0) begin
      r = sb.pop_front();
      check("out_data", bus.out_data, r[31:0]);
      check("out_dst",  32'(bus.out_dst), 32'(r[36:32]));
    end else if (m_ov && bus.flush && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    push = bus.req_valid && exp_req_rdy;
    pop  = bus.resp_valid && exp_resp_rdy;
    nov  = m_ov;
    e    = '0;
    if (pop) begin
      e = m_q.pop_front();
      if (!e.drop && !bus.flush)
        sb.push_back({e.dst, model_extract(e.op, e.addr, e.rt, bus.resp_data)});
    end
    if (bus.flush)               nov = 1'b0;
    else if (pop && !e.drop)     nov = 1'b1;
    else if (bus.out_ready)      nov = 1'b0;
    if (push) m_q.push_back('{op: bus.req_op, addr: bus.req_addr, rt: bus.req_rt,
                              dst: bus.req_dst, drop: 1'b0});
    if (bus.flush) foreach (m_q[i]) m_q[i].drop = 1'b1;
    @(posedge clk);
    m_ov = nov;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    check({tag, "_resp_ready"}, 32'(bus.resp_ready), 32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_out_data"},   bus.out_data,        32'd0);
    check({tag, "_out_dst"},    32'(bus.out_dst),    32'd0);
  endtask

  decoded_op_t ext_ops  [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_NONE, OP_LWL, OP_LWR};
  logic [1:0]  ext_addr [8] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

  initial begin
    resetn = 1'b0;
    clear_inputs();
    bus.out_ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Sign/zero extension, an unknown op, and LWL/LWR merges.
    for (int i = 0; i < 8; i++) begin
      drive_req(ext_ops[i], ext_addr[i], 32'h1122_3344, 5'(i + 1));
      tick();
      drive_resp(i < 6 ? 32'h8081_F2F3 : 32'hAABB_CCDD);
      tick();
    end
    tick();

    // A response while empty is ignored.
    drive_resp(32'hDEAD_BEEF);
    tick();
    tick();

    // Fill to full, refuse a fifth load, drain back-to-back; repeat to wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) begin
        drive_req(decoded_op_t'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                  $urandom, 5'(8 + rep * 4 + i));
        tick();
      end
      drive_req(OP_LW, 2'd0, '0, 5'd31);
      tick();
      for (int i = 0; i < 4; i++) begin
        drive_resp($urandom);
        tick();
      end
      tick();
      check("wrap_drained", 32'(sb.size() + m_q.size()), 32'd0);
    end

    // Backpressure: the second pop waits until the output drains.
    bus.out_ready = 1'b0;
    drive_req(OP_LW, 2'd0, '0, 5'd3);  tick();
    drive_req(OP_LHU, 2'd2, '0, 5'd4); tick();
    for (int k = 0; k < 3; k++) begin
      drive_resp(32'hC0DE_0000 + 32'(k));
      tick();
    end
    bus.out_ready = 1'b1;
    drive_resp(32'h9876_5432);
    tick();
    tick();
    tick();
    check("bp_drained", 32'(sb.size() + m_q.size()), 32'd0);

    // Flush with 3 outstanding loads, then one live LW to dst 7.
    for (int i = 0; i < 3; i++) begin
      drive_req(OP_LW, 2'd0, '0, 5'(20 + i));
      tick();
    end
    bus.flush = 1'b1;
    drive_req(OP_LB, 2'd1, '0, 5'd30);
    tick();
    drive_req(OP_LW, 2'd0, '0, 5'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_resp(32'h0F0F_0000 + 32'(i));
      tick();
    end
    tick();
    check("flush_drained", 32'(sb.size() + m_q.size()), 32'd0);

    // Flush while a result is held by backpressure: the result is discarded.
    bus.out_ready = 1'b0;
    drive_req(OP_LW, 2'd0, '0, 5'd9); tick();
    drive_resp(32'h5555_AAAA);        tick();
    bus.flush = 1'b1;                 tick();
    bus.out_ready = 1'b1;             tick();

    // Reset mid-stream: 2 queued and out_valid high.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(OP_LW, 2'd0, '0, 5'(11 + i));
      tick();
    end
    drive_resp(32'h1357_9BDF);
    tick();
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_q.delete();
    sb.delete();
    m_ov = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    drive_req(OP_LBU, 2'd2, '0, 5'd17); tick();
    drive_resp(32'h00AB_0000);          tick();
    tick();

    check("final_drained", 32'(sb.size() + m_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
